// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned STRB_W     = DATA_W_DEF / 8;
    localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/strobe_ram.sv
// Word-addressed data array with byte-strobed synchronous write and combinational read.
module strobe_ram #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: range check, programmable read latency,
// registered response held until the initiator takes it.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               addr_ok;
    logic [IDX_W-1:0]   req_idx;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_raddr;
    logic [DATA_W-1:0]  ram_rdata;

    assign addr_ok   = 32'(req_addr) < MEM_DEPTH;
    assign req_idx   = req_addr[IDX_W-1:0];
    assign ram_we    = req_valid && (state_q == StIdle) && req_write && addr_ok;
    // Latency-1 reads sample the array directly at the accept edge.
    assign ram_raddr = (state_q == StIdle) ? req_idx : addr_q;

    strobe_ram #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (req_idx),
        .wdata (req_wdata),
        .wstrb (req_wstrb),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (!addr_ok) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StResp;
                    end else if (req_write) begin
                        err_d   = 1'b0;
                        rdata_d = '0;
                        state_d = StResp;
                    end else if (READ_LATENCY == 1) begin
                        err_d   = 1'b0;
                        rdata_d = ram_rdata;
                        state_d = StResp;
                    end else begin
                        addr_d  = req_idx;
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    err_d   = 1'b0;
                    rdata_d = ram_rdata;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for load/store traffic. It accepts one read or write request at a time over a valid/ready request channel.
- It services each request against a word-addressed, byte-strobed data array. It returns one response per request on a valid/ready response channel.
- It sits between the load/store unit (the initiator) and the data memory.
- The read/write encoding matches read_write_select: 0 means read, 1 means write.

Parameters:
- DATA_W, 64, data word width in bits; must be a multiple of 8.
- ADDR_W, 8, word-address width.
- MEM_DEPTH, 256, number of implemented words; must be ≤ 2**ADDR_W.
- READ_LATENCY, 2, cycles from the read accept edge to the first resp_valid cycle; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  0 = read, 1 = write.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte enables for writes.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator takes the response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  address ≥ MEM_DEPTH.

Behaviour:
- Reset (asynchronous) forces:
  - state = IDLE, so req_ready = 1 once the FSM is in IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - Array contents are not reset.
  - Handshakes are ignored while reset is high.
- FSM states are IDLE, WAIT and RESP.
  - req_ready = (state == IDLE), decoded from registered state only.
  - An accept is req_valid & req_ready sampled at a rising edge.
- IDLE, accept with an error address (req_addr ≥ MEM_DEPTH), read or write:
  - No array access.
  - Go to RESP with resp_err = 1 and resp_rdata = 0.
  - resp_valid is high in the cycle after the accept edge.
- IDLE, accept of a valid write:
  - Bytes with req_wstrb[i] = 1 are written at the accept edge; other bytes are unchanged.
  - wstrb = 0 is a legal no-op write.
  - Go to RESP with resp_err = 0 and resp_rdata = 0.
- IDLE, accept of a valid read:
  - Capture the address.
  - If READ_LATENCY == 1, go to RESP and load resp_rdata = mem[addr] at the accept edge.
  - Otherwise go to WAIT with counter = READ_LATENCY - 1.
  - In WAIT, decrement the counter each cycle. On the edge where the counter reaches 0, load resp_rdata = mem[addr] and go to RESP.
  - Net effect: resp_valid first rises exactly READ_LATENCY cycles after the accept edge.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready = 1 is sampled.
  - On that edge: return to IDLE, clear resp_valid, and zero resp_rdata and resp_err.
  - No new request is accepted in the same cycle as a response is taken.
- Throughput: one request at a time.
  - Back-to-back writes with resp_ready held at 1: one accept every 2 cycles.
  - Reads: one accept every READ_LATENCY + 1 cycles.
- Ordering: a write is committed before its response, so any later read returns the new data.
- Request inputs are don't-care outside accept cycles.
- Reset mid-operation:
  - An in-flight read is dropped and no response is produced.
  - A write already accepted stays committed.
  - A pending response is discarded.

Decomposition:
- Package data_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - localparam STRB_W = DATA_W/8;
  - localparam CNT_W = 4.
- One natural sub-module, strobe_ram:
  - synchronous byte-strobed write;
  - combinational or registered read port;
  - DATA_W and MEM_DEPTH parameters;
  - no reset.
- data_mem_responder owns the FSM, the counter, range checking and the response registers.

Test Plan:
- Reset and idle: assert reset mid-cycle with resp_ready = 1 -> resp_valid = 0, resp_rdata = 0, resp_err = 0 immediately. After release, req_ready = 1.
- Write then read:
  - Stimulus: write addr 0x05, wdata 0x1122334455667788, wstrb 0xFF; then read addr 0x05 with READ_LATENCY = 2.
  - Write -> resp_valid 1 cycle after accept, rdata 0, err 0.
  - Read -> resp_valid exactly 2 cycles after accept, rdata 0x1122334455667788.
- Partial strobe: over that data, write addr 0x05 wdata 0xAAAAAAAAAAAAAAAA wstrb 0x0F -> a read returns 0x11223344AAAAAAAA. A write with wstrb 0x00 leaves the data unchanged.
- Backpressure: hold resp_ready = 0 for 5 cycles during a read response -> resp_valid, resp_rdata and resp_err are stable and req_ready = 0 throughout. Release -> return to IDLE the next cycle.
- Error: with MEM_DEPTH = 200, read addr 0xC8 (200) -> resp_err = 1, rdata 0 one cycle after accept. Write addr 0xFF -> resp_err = 1 and the array is unmodified.
- Reset mid-read: accept a read with READ_LATENCY = 4, assert reset in the WAIT state -> no response ever appears. After release, a fresh read of a previously written address returns the correct data; sweep READ_LATENCY ∈ {1, 15}.
